// File: rtl/imem_boot_loader_pkg.sv
// boot_pkg: shared definitions for the instruction-memory boot loader.
//   - boot_state_e : loader FSM states
//   - HDR_BYTES    : length header size in bytes (LEN_LO, LEN_HI)
//   - CSUM_BYTES   : trailing checksum size in bytes
//   - len_ok()     : accepts a word count only if 1 <= n <= depth
`timescale 1ns/1ps
package boot_pkg;

    typedef enum logic [2:0] {
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } boot_state_e;

    localparam int HDR_BYTES  = 2;
    localparam int CSUM_BYTES = 1;

    // A zero-length image has nothing to run, and anything longer than the
    // memory would overrun it, so both are rejected before any write.
    function automatic logic len_ok(input logic [15:0] n, input int depth);
        return (n != 16'd0) && (32'(n) <= depth);
    endfunction

endpackage

// File: rtl/imem_boot_loader_byte_packer.sv
// byte_packer: assembles four little-endian bytes into one 32-bit word.
// Ports:
//   clk, rst_n   : clock, synchronous active-low reset
//   in_valid     : a data byte transfers this cycle
//   in_byte      : the byte (first byte of a word lands in bits 7:0)
//   word_valid   : combinational pulse on the cycle the 4th byte arrives
//   word         : assembled word, meaningful while word_valid is high
`timescale 1ns/1ps
module byte_packer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [7:0]  in_byte,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0]  lane_q, lane_d;
    // Bytes 0..2 of the current word; byte 3 is merged straight from the
    // input so the completed word is available in the same cycle.
    logic [23:0] asm_q, asm_d;

    always_comb begin
        lane_d     = lane_q;
        asm_d      = asm_q;
        word_valid = 1'b0;
        word       = {in_byte, asm_q};
        if (in_valid) begin
            lane_d     = lane_q + 2'd1;    // wraps 3 -> 0 on word completion
            asm_d      = {in_byte, asm_q[23:8]};
            word_valid = (lane_q == 2'd3);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lane_q <= 2'd0;
            asm_q  <= 24'd0;
        end else begin
            lane_q <= lane_d;
            asm_q  <= asm_d;
        end
    end

endmodule

// File: rtl/imem_boot_loader.sv
// imem_boot_loader: receives a framed program image as a byte stream,
// writes it word by word into instruction memory and releases the core
// only when the whole image arrived with a matching checksum.
// Frame: LEN_LO, LEN_HI (word count N), 4*N data bytes, checksum byte
// (8-bit sum of the data bytes only).
// Ports:
//   clk, rst_n              : clock, synchronous active-low reset
//   byte_valid, byte_data   : upstream byte stream
//   byte_ready              : loader accepts a byte this cycle
//   imem_we/waddr/wdata     : registered instruction memory write port
//   core_rst_n              : core reset, low holds the core
//   busy, done, err         : loader status
`timescale 1ns/1ps
import boot_pkg::*;

module imem_boot_loader #(
    parameter int IMEM_DEPTH = 64,
    parameter int ADDR_W     = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [31:0]       imem_wdata,
    output logic              core_rst_n,
    output logic              busy,
    output logic              done,
    output logic              err
);

    boot_state_e       state_q, state_d;
    logic [7:0]        len_lo_q, len_lo_d;
    logic [15:0]       n_q, n_d;
    logic [15:0]       word_cnt_q, word_cnt_d;
    logic [7:0]        sum_q, sum_d;
    logic              imem_we_q, imem_we_d;
    logic [ADDR_W-1:0] imem_waddr_q, imem_waddr_d;
    logic [31:0]       imem_wdata_q, imem_wdata_d;

    logic              xfer;
    logic              pack_valid;
    logic              word_valid;
    logic [31:0]       word;

    assign byte_ready = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) ||
                        (state_q == S_DATA)   || (state_q == S_CSUM);
    assign xfer       = byte_valid && byte_ready;
    assign pack_valid = xfer && (state_q == S_DATA);

    byte_packer u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (pack_valid),
        .in_byte    (byte_data),
        .word_valid (word_valid),
        .word       (word)
    );

    always_comb begin
        state_d      = state_q;
        len_lo_d     = len_lo_q;
        n_d          = n_q;
        word_cnt_d   = word_cnt_q;
        sum_d        = sum_q;
        imem_we_d    = 1'b0;
        imem_waddr_d = imem_waddr_q;
        imem_wdata_d = imem_wdata_q;

        case (state_q)
            S_LEN_LO: begin
                if (xfer) begin
                    len_lo_d = byte_data;
                    state_d  = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (xfer) begin
                    n_d     = {byte_data, len_lo_q};
                    state_d = len_ok({byte_data, len_lo_q}, IMEM_DEPTH) ? S_DATA : S_ERR;
                end
            end
            S_DATA: begin
                if (xfer) begin
                    sum_d = sum_q + byte_data;
                    if (word_valid) begin
                        imem_we_d    = 1'b1;
                        imem_waddr_d = word_cnt_q[ADDR_W-1:0];
                        imem_wdata_d = word;
                        word_cnt_d   = word_cnt_q + 16'd1;
                        // Last word completes the data section; its write
                        // lands in the first checksum cycle.
                        if (word_cnt_q + 16'd1 == n_q) begin
                            state_d = S_CSUM;
                        end
                    end
                end
            end
            S_CSUM: begin
                if (xfer) begin
                    state_d = (byte_data == sum_q) ? S_DONE : S_ERR;
                end
            end
            default: begin
                state_d = state_q;    // S_DONE / S_ERR hold until reset
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_LEN_LO;
            len_lo_q     <= 8'd0;
            n_q          <= 16'd0;
            word_cnt_q   <= 16'd0;
            sum_q        <= 8'd0;
            imem_we_q    <= 1'b0;
            imem_waddr_q <= '0;
            imem_wdata_q <= 32'd0;
        end else begin
            state_q      <= state_d;
            len_lo_q     <= len_lo_d;
            n_q          <= n_d;
            word_cnt_q   <= word_cnt_d;
            sum_q        <= sum_d;
            imem_we_q    <= imem_we_d;
            imem_waddr_q <= imem_waddr_d;
            imem_wdata_q <= imem_wdata_d;
        end
    end

    assign imem_we    = imem_we_q;
    assign imem_waddr = imem_waddr_q;
    assign imem_wdata = imem_wdata_q;
    assign busy       = (state_q == S_LEN_HI) || (state_q == S_DATA) || (state_q == S_CSUM);
    assign done       = (state_q == S_DONE);
    assign err        = (state_q == S_ERR);
    assign core_rst_n = (state_q == S_DONE);

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader. A frame-position model follows
// the byte stream and predicts every output cycle by cycle; directed frames
// plus randomized frames exercise it, and literal checks pin the results.
`timescale 1ns/1ps
module tb_imem_boot_loader;

    localparam int IMEM_DEPTH = 64;
    localparam int ADDR_W     = 6;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              byte_valid = 1'b0;
    logic [7:0]        byte_data = 8'd0;
    logic              byte_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_waddr;
    logic [31:0]       imem_wdata;
    logic              core_rst_n;
    logic              busy;
    logic              done;
    logic              err;

    imem_boot_loader #(.IMEM_DEPTH(IMEM_DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .imem_we    (imem_we),
        .imem_waddr (imem_waddr),
        .imem_wdata (imem_wdata),
        .core_rst_n (core_rst_n),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Tracks position in the frame (bytes consumed) and an outcome:
    // 0 = still loading, 1 = accepted, 2 = rejected.
    int          m_pos = 0;
    int          m_n = 0;
    int          m_status = 0;
    logic [7:0]  m_lenlo = 8'd0;
    logic [7:0]  m_sum = 8'd0;
    logic [31:0] m_word = 32'd0;
    logic        exp_we = 1'b0;
    logic [ADDR_W-1:0] exp_waddr = '0;
    logic [31:0] exp_wdata = 32'd0;
    bit          m_started = 1'b0;
    bit          m_in_reset = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_pos = 0; m_status = 0; m_sum = 8'd0; m_n = 0;
            exp_we = 1'b0; exp_waddr = '0; exp_wdata = 32'd0;
            m_started = 1'b1; m_in_reset = 1'b1;
        end else begin
            m_in_reset = 1'b0;
            exp_we = 1'b0;
            if (m_status == 0 && byte_valid) begin
                if (m_pos == 0) begin
                    m_lenlo = byte_data;
                end else if (m_pos == 1) begin
                    m_n = int'({byte_data, m_lenlo});
                    if (m_n < 1 || m_n > IMEM_DEPTH) m_status = 2;
                end else if (m_pos <= 4 * m_n + 1) begin
                    int k;
                    k = m_pos - 2;
                    m_sum = m_sum + byte_data;
                    m_word[8 * (k % 4) +: 8] = byte_data;
                    if (k % 4 == 3) begin
                        exp_we    = 1'b1;
                        exp_waddr = ADDR_W'(k / 4);
                        exp_wdata = m_word;
                    end
                end else begin
                    m_status = (byte_data == m_sum) ? 1 : 2;
                end
                m_pos++;
            end
        end
    end

    // Write log captured from the DUT, cleared whenever reset is applied.
    int          wcount = 0;
    logic [5:0]  log_addr [0:127];
    logic [31:0] log_data [0:127];

    always @(negedge clk) begin
        if (m_started) begin
            check("byte_ready", 32'(byte_ready), 32'(m_status == 0));
            check("busy",       32'(busy),       32'(m_status == 0 && m_pos >= 1));
            check("done",       32'(done),       32'(m_status == 1));
            check("err",        32'(err),        32'(m_status == 2));
            check("core_rst_n", 32'(core_rst_n), 32'(m_status == 1));
            check("imem_we",    32'(imem_we),    32'(exp_we));
            if (exp_we) begin
                check("imem_waddr", 32'(imem_waddr), 32'(exp_waddr));
                check("imem_wdata", imem_wdata, exp_wdata);
            end
            if (m_in_reset) begin
                wcount = 0;
            end else if (imem_we) begin
                if (wcount < 128) begin
                    log_addr[wcount] = imem_waddr;
                    log_data[wcount] = imem_wdata;
                end
                wcount++;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    logic [7:0] frame [$];

    task automatic send_byte(input logic [7:0] b, input int gap);
        @(negedge clk);
        byte_valid = 1'b1;
        byte_data  = b;
        repeat (gap) begin
            @(negedge clk);
            byte_valid = 1'b0;
            byte_data  = 8'($urandom);
        end
    endtask

    // gap < 0 selects a random 0..2 idle cycles between bytes.
    task automatic send_frame(input int gap);
        foreach (frame[i]) send_byte(frame[i], (gap < 0) ? int'($urandom_range(0, 2)) : gap);
        @(negedge clk);
        byte_valid = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        byte_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic build_sample(input logic [7:0] csum);
        // Two words 0x00100513, 0x00200593; their data-byte sum is 0xE0.
        frame = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00, csum};
    endtask

    task automatic check_sample_writes(input string tag);
        check({tag, "_wcount"}, 32'(wcount), 32'd2);
        check({tag, "_addr0"},  32'(log_addr[0]), 32'd0);
        check({tag, "_data0"},  log_data[0], 32'h00100513);
        check({tag, "_addr1"},  32'(log_addr[1]), 32'd1);
        check({tag, "_data1"},  log_data[1], 32'h00200593);
    endtask

    task automatic check_status(input string tag, input logic d, input logic e);
        check({tag, "_done"},       32'(done),       32'(d));
        check({tag, "_err"},        32'(err),        32'(e));
        check({tag, "_core_rst_n"}, 32'(core_rst_n), 32'(d));
        check({tag, "_byte_ready"}, 32'(byte_ready), 32'd0);
    endtask

    initial begin
        // Reset values
        @(negedge clk);
        @(negedge clk);
        check("rst_byte_ready", 32'(byte_ready), 32'd1);
        check("rst_imem_we",    32'(imem_we),    32'd0);
        check("rst_imem_waddr", 32'(imem_waddr), 32'd0);
        check("rst_imem_wdata", imem_wdata,      32'd0);
        check("rst_core_rst_n", 32'(core_rst_n), 32'd0);
        check("rst_busy",       32'(busy),       32'd0);
        check("rst_done",       32'(done),       32'd0);
        check("rst_err",        32'(err),        32'd0);
        rst_n = 1'b1;

        // Good image; done/core_rst_n one cycle after the checksum byte
        build_sample(8'hE0);
        for (int i = 0; i < 10; i++) send_byte(frame[i], 0);
        send_byte(8'hE0, 0);
        @(negedge clk);
        byte_valid = 1'b0;
        check("good_done_timing", 32'(done), 32'd1);
        check("good_core_timing", 32'(core_rst_n), 32'd1);
        check("model_sum", 32'(m_sum), 32'hE0);
        repeat (3) @(negedge clk);
        check_sample_writes("good");
        check_status("good", 1'b1, 1'b0);

        // Bad checksum
        do_reset();
        build_sample(8'hE4);
        send_frame(0);
        check_sample_writes("badcsum");
        check_status("badcsum", 1'b0, 1'b1);

        // Zero length, trailing bytes must be ignored
        do_reset();
        frame = '{8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
        send_frame(0);
        check("len0_wcount", 32'(wcount), 32'd0);
        check_status("len0", 1'b0, 1'b1);

        // Length one beyond depth
        do_reset();
        frame = '{8'h41, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        send_frame(0);
        check("len65_wcount", 32'(wcount), 32'd0);
        check_status("len65", 1'b0, 1'b1);

        // Throttled: 3 idle cycles between bytes
        do_reset();
        build_sample(8'hE0);
        send_frame(3);
        check_sample_writes("thr");
        check_status("thr", 1'b1, 1'b0);

        // Reset after 5th data byte, then full good image
        do_reset();
        frame = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93};
        foreach (frame[i]) send_byte(frame[i], 0);
        @(negedge clk);
        byte_valid = 1'b0;
        check("mid_wcount_before", 32'(wcount), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        build_sample(8'hE0);
        send_frame(0);
        check_sample_writes("mid");
        check_status("mid", 1'b1, 1'b0);

        // Full depth: 64 words 0..63, data-byte sum 2016 mod 256 = 0xE0
        do_reset();
        frame = '{8'h40, 8'h00};
        for (int i = 0; i < 64; i++) begin
            frame.push_back(8'(i));
            frame.push_back(8'h00);
            frame.push_back(8'h00);
            frame.push_back(8'h00);
        end
        frame.push_back(8'hE0);
        send_frame(0);
        check("full_wcount", 32'(wcount), 32'd64);
        check("full_addr10", 32'(log_addr[10]), 32'd10);
        check("full_data10", log_data[10], 32'h0000000A);
        check("full_addr63", 32'(log_addr[63]), 32'd63);
        check("full_data63", log_data[63], 32'h0000003F);
        check_status("full", 1'b1, 1'b0);

        // Randomized frames
        for (int t = 0; t < 25; t++) begin
            int          n;
            bit          len_good;
            bit          csum_good;
            logic [7:0]  s;
            do_reset();
            case ($urandom_range(0, 7))
                0:       n = 0;
                1:       n = IMEM_DEPTH + 1 + int'($urandom_range(0, 300));
                default: n = int'($urandom_range(1, 10));
            endcase
            len_good  = (n >= 1 && n <= IMEM_DEPTH);
            csum_good = ($urandom_range(0, 3) != 0);
            frame = '{8'(n), 8'(n >> 8)};
            s = 8'd0;
            if (len_good) begin
                for (int i = 0; i < 4 * n; i++) begin
                    logic [7:0] b;
                    b = 8'($urandom);
                    s = s + b;
                    frame.push_back(b);
                end
                frame.push_back(csum_good ? s : s + 8'(int'($urandom_range(1, 255))));
            end
            for (int i = 0; i < int'($urandom_range(0, 3)); i++) frame.push_back(8'($urandom));
            send_frame(-1);
            check("rand_wcount", 32'(wcount), 32'(len_good ? n : 0));
            check_status("rand", len_good && csum_good, !(len_good && csum_good));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
